// File: rtl/booth_display_pkg.sv
// Shared types and constants for the Booth product display path.
// The optional LEADING_ZERO_BLANK_EN build is handled in the top-level decode.
package booth_display_pkg;

   localparam int unsigned BIN_W  = 8;
   localparam int unsigned BCD_W  = 12;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned SEG_W  = 7;
   localparam int unsigned STEP_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_e;

   // Three BCD digits, hundreds in the top nibble
   typedef struct packed {
      logic [NIB_W-1:0] hund;
      logic [NIB_W-1:0] tens;
      logic [NIB_W-1:0] units;
   } bcd_t;

   // Active-low cathodes ordered {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   function automatic logic [SEG_W-1:0] digit_to_seg(input logic [NIB_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: add 3 to every nibble that is 5 or more
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < int'(BCD_W / NIB_W); i++) begin
         if (r[i*NIB_W +: NIB_W] >= 4'd5)
            r[i*NIB_W +: NIB_W] = r[i*NIB_W +: NIB_W] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: 8-bit unsigned to three BCD digits in 8 steps,
// plus one DONE cycle during which bcd holds the result and done is high.
module bin2bcd_serial
   import booth_display_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       bin,
   output logic [11:0]      bcd,
   output logic             done
);

   conv_state_e        state, state_nxt;
   logic [BCD_W-1:0]   sh_bcd, sh_bcd_nxt;
   logic [BIN_W-1:0]   sh_bin, sh_bin_nxt;
   logic [STEP_W-1:0]  step, step_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sh_bcd <= '0;
         sh_bin <= '0;
         step   <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         sh_bcd <= sh_bcd_nxt;
         sh_bin <= sh_bin_nxt;
         step   <= step_nxt;
         done   <= (state_nxt == DONE);
      end
   end

   // Next-state and datapath step
   always_comb begin
      state_nxt  = state;
      sh_bcd_nxt = sh_bcd;
      sh_bin_nxt = sh_bin;
      step_nxt   = step;
      case (state)
         IDLE: begin
            if (start) begin
               sh_bin_nxt = bin;
               sh_bcd_nxt = '0;
               step_nxt   = '0;
               state_nxt  = CONV;
            end
         end
         CONV: begin
            {sh_bcd_nxt, sh_bin_nxt} = {dd_adjust(sh_bcd), sh_bin} << 1;
            step_nxt = STEP_W'(step + STEP_W'(1));
            if (step == STEP_W'(7))
               state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bcd = sh_bcd;

endmodule

// File: rtl/product_display_driver.sv
// Converts the signed Booth product to sign + 3 BCD digits and scans them onto
// the 4-digit seven-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module product_display_driver
   import booth_display_pkg::*;
#(
   parameter int unsigned CNT_W = 18
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  p,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        busy
);

   logic [BIN_W-1:0]  p_last;
   logic              sign_conv;
   logic              sign_disp;
   bcd_t              disp;
   logic [CNT_W-1:0]  cnt;

   logic              start_c;
   logic [BIN_W-1:0]  mag_c;
   logic [BCD_W-1:0]  conv_bcd;
   logic              conv_done;
   logic [CNT_W-1:0]  cnt_nxt_c;
   logic [1:0]        sel_c;
   logic [3:0]        an_nxt_c;
   logic [SEG_W-1:0]  seg_nxt_c;

   // A new conversion starts only once the previous one has fully retired
   assign start_c   = !busy && (p != p_last);
   assign mag_c     = p[7] ? BIN_W'(~p + BIN_W'(1)) : p;
   assign cnt_nxt_c = CNT_W'(cnt + CNT_W'(1));
   assign sel_c     = cnt_nxt_c[CNT_W-1 -: 2];

   bin2bcd_serial u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start_c),
      .bin   (mag_c),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   // Anode select and segment decode for the digit shown after this edge
   always_comb begin
      an_nxt_c  = 4'b1110;
      seg_nxt_c = SEG_BLANK;
      case (sel_c)
         2'd0: begin
            an_nxt_c  = 4'b1110;
            seg_nxt_c = digit_to_seg(disp.units);
         end
         2'd1: begin
            an_nxt_c  = 4'b1101;
            seg_nxt_c = digit_to_seg(disp.tens);
`ifdef LEADING_ZERO_BLANK_EN
            if ((disp.hund == 4'd0) && (disp.tens == 4'd0))
               seg_nxt_c = SEG_BLANK;
`endif
         end
         2'd2: begin
            an_nxt_c  = 4'b1011;
            seg_nxt_c = digit_to_seg(disp.hund);
`ifdef LEADING_ZERO_BLANK_EN
            if (disp.hund == 4'd0)
               seg_nxt_c = SEG_BLANK;
`endif
         end
         default: begin
            an_nxt_c  = 4'b0111;
            seg_nxt_c = sign_disp ? SEG_MINUS : SEG_BLANK;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_last    <= '0;
         sign_conv <= 1'b0;
         sign_disp <= 1'b0;
         disp      <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         an        <= 4'b1110;
         seg       <= SEG_0;
         dp        <= 1'b1;
      end else begin
         cnt <= cnt_nxt_c;
         an  <= an_nxt_c;
         seg <= seg_nxt_c;
         dp  <= 1'b1;
         if (start_c) begin
            p_last    <= p;
            sign_conv <= p[7];
            busy      <= 1'b1;
         end
         if (conv_done) begin
            disp      <= bcd_t'(conv_bcd);
            sign_disp <= sign_conv;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_product_display_driver.sv
// Directed bench for product_display_driver built with a 4-bit refresh counter.
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_product_display_driver;

   localparam int unsigned CNT_W = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] p;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int tb_cyc   = 0;

   product_display_driver #(.CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .p    (p),
      .an   (an),
      .seg  (seg),
      .dp   (dp),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // Edges since reset release; selects which digit should be lit
   always @(posedge clk or posedge rst) begin
      if (rst) tb_cyc <= 0;
      else     tb_cyc <= tb_cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] ref_digit(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic sample_check(input int s, input int h, input int t, input int u);
      int         sel;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      sel = (tb_cyc / 4) % 4;
      case (sel)
         0: begin exp_an = 4'b1110; exp_seg = ref_digit(u); end
         1: begin
            exp_an = 4'b1101; exp_seg = ref_digit(t);
`ifdef LEADING_ZERO_BLANK_EN
            if (h == 0 && t == 0) exp_seg = 7'b1111111;
`endif
         end
         2: begin
            exp_an = 4'b1011; exp_seg = ref_digit(h);
`ifdef LEADING_ZERO_BLANK_EN
            if (h == 0) exp_seg = 7'b1111111;
`endif
         end
         default: begin exp_an = 4'b0111; exp_seg = (s != 0) ? 7'b0111111 : 7'b1111111; end
      endcase
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
   endtask

   task automatic scan_check(input int s, input int h, input int t, input int u);
      for (int i = 0; i < 16; i++) begin
         sample_check(s, h, t, u);
         tick();
      end
   endtask

   // Conversion already triggered: busy must last 9 cycles, then the scan shows the value
   task automatic run_conv(input string tag, input int s, input int h, input int t, input int u);
      int nb;
      nb = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (busy) nb++;
      end
      check({tag, "_busy_len"}, 32'(nb), 32'd9);
      scan_check(s, h, t, u);
   endtask

   initial begin
      int k;
      int nb;
      rst = 1'b1;
      p   = 8'h00;
      #12;
      check("rst_an", 32'(an), 32'b1110);
      check("rst_seg", 32'(seg), 32'b1000000);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Zero product after reset: nothing to convert
      nb = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy) nb++;
      end
      check("idle_busy", 32'(nb), 32'd0);
      scan_check(0, 0, 0, 0);

      p = 8'h15; run_conv("p15", 0, 0, 2, 1);
      p = 8'hC8; run_conv("pC8", 1, 0, 5, 6);
      p = 8'h80; run_conv("p80", 1, 1, 2, 8);
      p = 8'h7F; run_conv("p7F", 0, 1, 2, 7);

      // p changes during conversion: first result shown, then an immediate second conversion
      p = 8'h15;
      tick();
      check("mid_start", 32'(busy), 32'd1);
      repeat (3) tick();
      p = 8'h09;
      k = 0;
      while (busy && k < 20) begin
         tick();
         k++;
      end
      check("mid_first_len", 32'(k), 32'd6);
      tick();
      check("mid_restart", 32'(busy), 32'd1);
      for (int i = 0; i < 10; i++) begin
         sample_check(0, 0, 2, 1);
         tick();
      end
      check("mid_second_done", 32'(busy), 32'd0);
      scan_check(0, 0, 0, 9);

      // Reset during CONV aborts at once; conversion restarts after release
      p = 8'h33;
      tick();
      tick();
      check("abort_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_an", 32'(an), 32'b1110);
      check("abort_seg", 32'(seg), 32'b1000000);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_dp", 32'(dp), 32'd1);
      #2;
      rst = 1'b0;
      run_conv("p33", 0, 0, 5, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/product_display_driver.md
Name: product_display_driver

Overview:
- Downstream stage of the combinational Booth multiplier on the Atlys board.
- Takes the 8-bit two's-complement product `p` and converts it serially (double-dabble) into sign plus three BCD digits.
- Drives the 4-digit multiplexed seven-segment display as: sign, hundreds, tens, units.
- All display outputs are registered.

Parameters:
- CNT_W, 18, refresh counter width; counter bits [CNT_W-1:CNT_W-2] select the active digit (≈381 Hz frame at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- p  in  8  signed product from the multiplier; may change asynchronously to conversion.
- an  out  4  digit anodes, active-low; an[3]=sign, an[2]=hundreds, an[1]=tens, an[0]=units.
- seg  out  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low; constant 1 (off).
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, p_last=0, refresh counter=0, BCD display registers=0, sign register=0.
  - an=4'b1110, seg=7'b1000000 ('0'), dp=1, busy=0.
- States:
  - IDLE: on the edge where p != p_last:
    - latch p_last=p, sign=p[7], mag = p[7] ? -p : p, with mag 8-bit unsigned so 8'h80 → 128.
    - clear BCD shift register and bit counter; go to CONV; busy=1.
  - CONV: each edge performs one double-dabble step:
    - first, add 3 to every BCD nibble ≥5;
    - then shift {bcd,mag} left by 1; counter++.
    - After the 8th step (counter==7 at the edge), go to DONE.
  - DONE: one edge; copy the 12-bit BCD and sign into the display registers; busy=0; return to IDLE.
- Latency: p sampled at edge E0 → display registers updated at E9 → visible on seg no later than the next scan of each digit.
- p changes during CONV/DONE are ignored for the current conversion. On return to IDLE, p != p_last triggers a new conversion on the next edge. No value is lost; the last stable p is always displayed.
- A constant p produces no further conversions; busy stays 0.
- Refresh counter:
  - free-running, wraps 2^CNT_W-1 → 0;
  - top 2 bits = 0,1,2,3 select an[0],an[1],an[2],an[3] respectively.
  - Exactly one an bit is low at any time.
  - an and seg are updated on the same edge (no ghosting).
- Sign digit shows minus (7'b0111111) when sign=1, otherwise blank (7'b1111111).
- Digit codes 0..9:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
- Range: -128..127. Hundreds digit is only ever 0 or 1.
- Reset asserted mid-conversion aborts immediately to reset values. After release, if p != 0, conversion restarts from IDLE.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - hundreds digit is blank when it is 0;
  - tens digit is blank when hundreds and tens are both 0;
  - units is always shown;
  - the minus sign stays in an[3].
- Undefined: all three numeric digits are always shown, e.g. "005".

Decomposition:
- Package booth_display_pkg holds:
  - state encoding (IDLE, CONV, DONE);
  - seven-segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK;
  - BCD width constant (12).
- Sub-module bin2bcd_serial holds the IDLE/CONV/DONE FSM and double-dabble datapath.
  - Ports: clk, rst, start, bin[7:0], bcd[11:0], done.
- The top level keeps change detection, the refresh scan, and the segment decode.

Test Plan:
- Reset release with p=8'h00 → busy stays 0; scan shows blank, 0, 0, 0 (blank, blank, blank, 0 with LEADING_ZERO_BLANK_EN).
- p=8'h15 (21) → busy high for 9 cycles; display registers = sign 0, 0/2/1 at E9; seg on an[1]=0100100, an[0]=1111001.
- p=8'hC8 (-56) → sign digit 0111111, digits 0, 5, 6.
- p=8'h80 → minus, 1, 2, 8; p=8'h7F → blank, 1, 2, 7.
- p changes 8'h15→8'h09 at cycle 3 of CONV → first result 021 shown, then a second conversion starts immediately and 009 is shown 10 cycles later.
- CNT_W=4 build: an sequence 1110, 1101, 1011, 0111 every 4 cycles and wraps. Assert rst mid-CONV → all outputs at reset values on the same cycle.
